// File: rtl/branch_resolver.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// branch_resolver: FIFO of fetch-time predictions, checked against execute
// outcomes; emits predictor/BTB training, fetch redirect and flush.  Rev 1.0
// =============================================================================
module branch_resolver #(
  parameter int PCSIZE = 12,
  parameter int DEPTH  = 4,
  parameter int CNTW   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pred_valid,
  input  logic [PCSIZE-1:0] pred_pc,
  input  logic              pred_taken,
  input  logic [PCSIZE-1:0] pred_target,
  output logic              pred_ready,
  input  logic              res_valid,
  input  logic              res_taken,
  input  logic [PCSIZE-1:0] res_target,
  output logic [2:0]        branch,
  output logic              outcome,
  output logic [PCSIZE-1:0] PCupdate,
  output logic [PCSIZE-1:0] target,
  output logic              redirect_valid,
  output logic [PCSIZE-1:0] redirect_pc,
  output logic              flush,
  output logic              res_err,
  output logic [CNTW-1:0]   br_count,
  output logic [CNTW-1:0]   mp_count
);
  localparam int              PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0]     OCC_FULL = (PW+1)'(DEPTH);
  localparam logic [CNTW-1:0] CNT_MAX  = '1;

  typedef enum logic [0:0] {RUN = 1'b0, FLUSH = 1'b1} state_t;
  state_t state;

  logic [PCSIZE-1:0] pc_mem  [DEPTH];
  logic              tk_mem  [DEPTH];
  logic [PCSIZE-1:0] tg_mem  [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [PW:0]       occ;

  logic              push, pop, mispredict;
  logic [PCSIZE-1:0] head_pc, head_tg;
  logic              head_tk;

  assign head_pc = pc_mem[rd_ptr];
  assign head_tk = tk_mem[rd_ptr];
  assign head_tg = tg_mem[rd_ptr];

  // Ready is held low while reset is asserted so every output reads 0 then.
  assign pred_ready = rst_n && (state == RUN) && (occ < OCC_FULL);
  assign pop        = (state == RUN) && res_valid && (occ != '0);
  // A not-taken/not-taken pair never compares targets.
  assign mispredict = pop && ((head_tk != res_taken) ||
                              (res_taken && (head_tg != res_target)));
  // A record pushed alongside a mispredict is wrong-path and is dropped.
  assign push       = pred_valid && pred_ready && !mispredict;

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr] <= pred_pc;
      tk_mem[wr_ptr] <= pred_taken;
      tg_mem[wr_ptr] <= pred_target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= RUN;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      occ            <= '0;
      branch         <= 3'b000;
      outcome        <= 1'b0;
      PCupdate       <= '0;
      target         <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      flush          <= 1'b0;
      res_err        <= 1'b0;
      br_count       <= '0;
      mp_count       <= '0;
    end else begin
      branch         <= 3'b000;
      redirect_valid <= 1'b0;
      flush          <= 1'b0;
      case (state)
        RUN: begin
          if (pop) begin
            branch   <= 3'b001;
            outcome  <= res_taken;
            PCupdate <= head_pc;
            target   <= res_target;
            if (br_count != CNT_MAX) br_count <= br_count + 1'b1;
          end else if (res_valid) begin
            res_err <= 1'b1;
          end

          if (mispredict) begin
            redirect_valid <= 1'b1;
            redirect_pc    <= res_taken ? res_target : head_pc + PCSIZE'(4);
            if (mp_count != CNT_MAX) mp_count <= mp_count + 1'b1;
            state  <= FLUSH;
            flush  <= 1'b1;
            occ    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
          end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      occ <= occ + 1'b1;
            else if (!push && pop) occ <= occ - 1'b1;
          end
        end
        FLUSH: begin
          state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_branch_resolver.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for branch_resolver: directed scenarios then random traffic, all
// compared against a queue-based reference model of the resolution rules.
module tb_branch_resolver;
  localparam int PCSIZE = 12;
  localparam int DEPTH  = 4;
  localparam int CNTW   = 16;
  localparam int CMAX   = (1 << CNTW) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              pred_valid = 1'b0, pred_taken = 1'b0;
  logic [PCSIZE-1:0] pred_pc = '0, pred_target = '0;
  logic              pred_ready;
  logic              res_valid = 1'b0, res_taken = 1'b0;
  logic [PCSIZE-1:0] res_target = '0;
  logic [2:0]        branch;
  logic              outcome, redirect_valid, flush, res_err;
  logic [PCSIZE-1:0] PCupdate, target, redirect_pc;
  logic [CNTW-1:0]   br_count, mp_count;

  always #5 clk = ~clk;

  branch_resolver #(.PCSIZE(PCSIZE), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
    .clk(clk), .rst_n(rst_n),
    .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_taken(pred_taken),
    .pred_target(pred_target), .pred_ready(pred_ready),
    .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
    .branch(branch), .outcome(outcome), .PCupdate(PCupdate), .target(target),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush),
    .res_err(res_err), .br_count(br_count), .mp_count(mp_count)
  );

  typedef struct {
    logic [PCSIZE-1:0] pc;
    logic              tk;
    logic [PCSIZE-1:0] tg;
  } rec_t;

  // Reference model: in-flight records in a queue plus expected outputs.
  rec_t              q[$];
  bit                m_fl;
  logic [2:0]        m_branch;
  logic              m_outcome, m_rv, m_err;
  logic [PCSIZE-1:0] m_pcu, m_tgt, m_rpc;
  int                m_br, m_mp;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_fl = 0; m_branch = 3'b000; m_outcome = 0; m_rv = 0; m_err = 0;
    m_pcu = '0; m_tgt = '0; m_rpc = '0; m_br = 0; m_mp = 0;
  endtask

  task automatic check_outputs();
    chk("branch",         32'(branch),         32'(m_branch));
    chk("outcome",        32'(outcome),        32'(m_outcome));
    chk("PCupdate",       32'(PCupdate),       32'(m_pcu));
    chk("target",         32'(target),         32'(m_tgt));
    chk("redirect_valid", 32'(redirect_valid), 32'(m_rv));
    chk("redirect_pc",    32'(redirect_pc),    32'(m_rpc));
    chk("flush",          32'(flush),          32'(m_fl));
    chk("res_err",        32'(res_err),        32'(m_err));
    chk("br_count",       32'(br_count),       32'(m_br));
    chk("mp_count",       32'(mp_count),       32'(m_mp));
  endtask

  // One clock: drive inputs, check ready, advance the model, check outputs.
  task automatic cycle(input logic pv, input logic [PCSIZE-1:0] ppc, input logic ptk,
                       input logic [PCSIZE-1:0] ptg, input logic rv, input logic rtk,
                       input logic [PCSIZE-1:0] rtg);
    bit                ready, push_ok, mis;
    rec_t              h;
    logic [PCSIZE-1:0] seq_pc;
    pred_valid = pv; pred_pc = ppc; pred_taken = ptk; pred_target = ptg;
    res_valid = rv; res_taken = rtk; res_target = rtg;
    #1;
    ready = !m_fl && (q.size() < DEPTH);
    chk("pred_ready", 32'(pred_ready), 32'(ready));
    m_branch = 3'b000;
    m_rv = 0;
    if (m_fl) begin
      m_fl = 0;
    end else begin
      push_ok = pv && ready;
      if (rv && q.size() > 0) begin
        h = q.pop_front();
        mis = (h.tk != rtk) || (rtk && h.tg != rtg);
        m_branch = 3'b001; m_outcome = rtk; m_pcu = h.pc; m_tgt = rtg;
        if (m_br < CMAX) m_br++;
        if (mis) begin
          seq_pc = h.pc + 12'd4;
          m_rv = 1;
          m_rpc = rtk ? rtg : seq_pc;
          if (m_mp < CMAX) m_mp++;
          q.delete();
          m_fl = 1;
          push_ok = 0;
        end
      end else if (rv) begin
        m_err = 1;
      end
      if (push_ok) q.push_back('{pc: ppc, tk: ptk, tg: ptg});
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic push(input logic [PCSIZE-1:0] pc, input logic tk, input logic [PCSIZE-1:0] tg);
    cycle(1'b1, pc, tk, tg, 1'b0, 1'b0, '0);
  endtask

  task automatic resolve(input logic tk, input logic [PCSIZE-1:0] tg);
    cycle(1'b0, '0, 1'b0, '0, 1'b1, tk, tg);
  endtask

  task automatic idle();
    cycle(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0);
  endtask

  // Correct resolution of the model's oldest record (target only matters if taken).
  task automatic resolve_ok(input logic pv, input logic [PCSIZE-1:0] ppc);
    logic [PCSIZE-1:0] tg;
    tg = q[0].tk ? q[0].tg : PCSIZE'($urandom);
    cycle(pv, ppc, 1'b1, 12'h300, 1'b1, q[0].tk, tg);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    logic [PCSIZE-1:0] exp_order [4];
    logic [PCSIZE-1:0] rtg, ptg;
    logic              rv, pv;

    model_reset();
    #2;
    chk("reset_pred_ready", 32'(pred_ready), 32'd0);
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_reset_ready", 32'(pred_ready), 32'd1);

    // Correctly predicted taken branch.
    push(12'h010, 1'b1, 12'h040);
    resolve(1'b1, 12'h040);
    chk("t1_branch",   32'(branch),   32'd1);
    chk("t1_pcupdate", 32'(PCupdate), 32'h010);
    chk("t1_redirect", 32'(redirect_valid), 32'd0);
    chk("t1_br_count", 32'(br_count), 32'd1);

    // Direction mispredict: predicted not-taken, actually taken.
    push(12'h020, 1'b0, 12'h000);
    resolve(1'b1, 12'h080);
    chk("t2_redirect",    32'(redirect_valid), 32'd1);
    chk("t2_redirect_pc", 32'(redirect_pc),    32'h080);
    chk("t2_mp_count",    32'(mp_count),       32'd1);
    chk("t2_flush_ready", 32'(pred_ready),     32'd0);
    idle();
    chk("t2_ready_after", 32'(pred_ready), 32'd1);

    // Fall-through redirect wraps past the top of the PC space.
    push(12'hFFC, 1'b1, 12'h100);
    resolve(1'b0, 12'h000);
    chk("t3_redirect_pc", 32'(redirect_pc), 32'h000);
    chk("t3_outcome",     32'(outcome),     32'd0);
    chk("t3_pcupdate",    32'(PCupdate),    32'hFFC);
    idle();

    // Fill to DEPTH, hold a fifth push, free a slot, check ordering.
    push(12'h100, 1'b1, 12'h1A0);
    push(12'h104, 1'b0, 12'h000);
    push(12'h108, 1'b1, 12'h1C0);
    push(12'h10C, 1'b0, 12'h000);
    cycle(1'b1, 12'h110, 1'b1, 12'h1E0, 1'b0, 1'b0, '0);
    resolve_ok(1'b1, 12'h110);
    chk("t4_not_taken_yet", 32'(q.size()), 32'd3);
    cycle(1'b1, 12'h110, 1'b1, 12'h1E0, 1'b0, 1'b0, '0);
    exp_order[0] = 12'h104; exp_order[1] = 12'h108;
    exp_order[2] = 12'h10C; exp_order[3] = 12'h110;
    for (int i = 0; i < 4; i++) begin
      resolve_ok(1'b0, '0);
      chk("t4_order", 32'(PCupdate), 32'(exp_order[i]));
    end

    // Mispredict the oldest of three while a fourth push is offered.
    push(12'h200, 1'b1, 12'h240);
    push(12'h204, 1'b1, 12'h250);
    push(12'h208, 1'b0, 12'h000);
    cycle(1'b1, 12'h20C, 1'b1, 12'h260, 1'b1, 1'b1, 12'h244);
    chk("t5_redirect_pc", 32'(redirect_pc), 32'h244);
    idle();
    resolve(1'b1, 12'h240);
    chk("t5_res_err", 32'(res_err), 32'd1);
    chk("t5_no_pulse", 32'(branch), 32'd0);

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      pv  = 1'($urandom_range(0, 1));
      rv  = ($urandom_range(0, 2) == 0);
      ptg = 12'h040 << $urandom_range(0, 3);
      if (rv && q.size() > 0 && $urandom_range(0, 3) != 0) begin
        rtg = q[0].tk ? q[0].tg : PCSIZE'($urandom);
        cycle(pv, PCSIZE'($urandom), 1'($urandom), ptg, 1'b1, q[0].tk, rtg);
      end else begin
        rtg = 12'h040 << $urandom_range(0, 3);
        cycle(pv, PCSIZE'($urandom), 1'($urandom), ptg, rv, 1'($urandom), rtg);
      end
    end

    // Asynchronous reset with two records queued and a resolution pending.
    while (m_fl) idle();
    for (int k = 0; k < 8 && q.size() > 2; k++) resolve_ok(1'b0, '0);
    for (int k = 0; k < 4 && q.size() < 2; k++) push(12'h300 + 12'(k * 4), 1'b1, 12'h340);
    chk("t6_queued", 32'(q.size()), 32'd2);
    pred_valid = 1'b0;
    res_valid = 1'b1; res_taken = q[0].tk; res_target = q[0].tg;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("t6_async_ready", 32'(pred_ready), 32'd0);
    check_outputs();
    res_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    idle();
    resolve(1'b1, 12'h340);
    chk("t6_no_training", 32'(branch), 32'd0);
    chk("t6_res_err", 32'(res_err), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/branch_resolver.md
Name: branch_resolver

Overview:
- Resolution end of the branch-prediction loop: tracks predictions issued at fetch and checks each one against the actual outcome computed at execute.
- Produces the per-branch training update (outcome, PCupdate, target, branch) consumed by the 2-bit predictor and BTB.
- On a misprediction, produces the fetch redirect and a pipeline flush.
- Sits between fetch (prediction side) and execute (resolution side).

Parameters:
- PCSIZE, 12, PC/target width in bits.
- DEPTH, 4, maximum in-flight predicted branches (power of 2, ≥2).
- CNTW, 16, width of statistics counters.

Ports:
- clk in 1: single clock, all state on rising edge.
- rst_n in 1: asynchronous active-low reset.
- pred_valid in 1: fetch pushes one prediction record.
- pred_pc in PCSIZE: PC of predicted branch.
- pred_taken in 1: predictor output (1 = taken).
- pred_target in PCSIZE: BTB target used at fetch.
- pred_ready out 1: record accepted this cycle.
- res_valid in 1: execute resolves the oldest in-flight branch.
- res_taken in 1: actual direction.
- res_target in PCSIZE: actual target.
- branch out 3: training enable to predictor/BTB; 3'b001 for one cycle per resolution, else 3'b000.
- outcome out 1: actual direction for training.
- PCupdate out PCSIZE: PC being trained.
- target out PCSIZE: actual target for BTB write.
- redirect_valid out 1: one-cycle mispredict pulse.
- redirect_pc out PCSIZE: correct fetch PC.
- flush out 1: high for the FLUSH state cycle.
- res_err out 1: sticky; set when res_valid arrives with no in-flight entry.
- br_count out CNTW: resolved branches, saturating.
- mp_count out CNTW: mispredictions, saturating.

Behaviour:
- Reset (async, rst_n=0):
  - FIFO emptied, occupancy 0, state RUN.
  - All outputs 0, except pred_ready=1 once rst_n=1.
  - Reset mid-operation discards all in-flight records; no training or redirect is emitted for them.
- Storage: DEPTH-entry FIFO of {pc, taken, target}.
  - Read/write pointers wrap modulo DEPTH; occupancy counter 0..DEPTH.
- pred_ready = (state==RUN) && (occupancy<DEPTH); combinational from registered state.
  - No push-on-full bypass, even when a pop occurs the same cycle.
- Push: occurs when pred_valid && pred_ready at a clock edge.
- Pop: occurs when res_valid && occupancy>0 in state RUN.
  - Compares the head record with res_taken/res_target.
- Mispredict condition: (head.taken != res_taken) || (res_taken && head.target != res_target).
  - Target is ignored when both directions are not-taken.
- Latency: all resolution outputs are registered and appear the cycle after the pop edge, for exactly one cycle.
  - branch=3'b001, outcome=res_taken, PCupdate=head.pc, target=res_target.
  - br_count+1.
  - On mispredict additionally:
    - redirect_valid=1.
    - redirect_pc = res_taken ? res_target : head.pc+4, with +4 wrapping mod 2^PCSIZE.
    - mp_count+1.
- Counters saturate at 2^CNTW-1.
- State machine: RUN, FLUSH.
  - RUN -> FLUSH on a mispredicting pop. At that edge, occupancy<=0 and both pointers<=0; all younger records are wrong-path and discarded.
  - FLUSH: flush=1, pred_ready=0, res_valid ignored (no err), pushes dropped. Lasts one cycle, then -> RUN.
- Simultaneous events:
  - Push + correct pop in RUN: both take effect; occupancy unchanged.
  - Push + mispredicting pop: push is dropped; FIFO ends empty.
  - res_valid while empty in RUN: no pop, no training pulse, res_err<=1 (cleared only by reset).
- When idle, branch, redirect_valid and flush are held at 0.
- outcome, PCupdate, target and redirect_pc hold their last values when idle.

Test Plan:
- Reset, then push {pc=0x010, taken=1, tgt=0x040}; next cycle res_valid taken=1 tgt=0x040 -> one cycle later branch=001, outcome=1, PCupdate=0x010, target=0x040, redirect_valid=0, br_count=1.
- Push {0x020, taken=0}; resolve taken=1 tgt=0x080 -> redirect_valid=1, redirect_pc=0x080, mp_count=1; next cycle flush=1 and pred_ready=0; then pred_ready=1 with FIFO empty.
- Push {0xFFC, taken=1, tgt=0x100}; resolve taken=0 -> redirect_pc=0x000 (wrap); training outcome=0, PCupdate=0xFFC.
- Push 4 records (DEPTH=4) -> pred_ready=0 with 5th pred_valid held; resolve one correctly while pred_valid stays high -> 5th accepted the cycle after pop, order preserved over 4 more resolutions.
- With 3 records queued, mispredict the oldest while pushing a 4th in the same cycle -> 4th dropped, occupancy 0, a following res_valid sets res_err=1 and emits no branch pulse.
- Assert rst_n=0 mid-stream with 2 records queued and res_valid high -> outputs 0 immediately (async); after release no training pulses for the old records.
